dcache_port_arb: RTL and testbench

Single-port D$ access arbiter between the load pipe, the store buffer drain and the line-fill engine. Each cycle it picks at most one requester, returns a same-cycle grant/ack, and drives one registered D$ command the next cycle. It locks the port for whole fill bursts and, when enabled, prevents store-drain starvation behind back-to-back loads. It sits between the e0 memory pipe / store buffer / miss unit and the D$ data/tag arrays.

---
 rtl/dcache_port_arb.sv | 226 ++++++++++++++++++++++
 tb/tb_dcache_port_arb.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_port_arb.sv
// -----------------------------------------------------------------------------
// dcache_port_arb
//
// Single-port D$ access arbiter between the load pipe (e0), the store buffer
// drain and the line-fill engine. At most one requester is granted per cycle
// (combinational grant/ack). The winner's command is registered onto the D$
// command bus on the following edge. A granted fill locks the port for the
// whole FILL_BEATS burst.
//
// Optional feature macro: DCARB_STARVE_EN
//   defined   : a 4-bit store wait counter promotes a store that has been
//               denied STARVE_MAX consecutive arbitration cycles above loads
//               (fill > starved store > load > store).
//   undefined : stores are strictly lowest priority (fill > load > store);
//               STARVE_MAX is only range-checked.
//
// Parameters
//   VA_BITS    : address width
//   STARVE_MAX : store denials before promotion (1..15)
//   FILL_BEATS : 64-bit beats per line fill (power of 2, 2..8)
//
// Ports
//   clk, reset                : core clock, asynchronous active-low reset
//   ld_req_e0/ld_va_e0        : load request/address;  ld_gnt_e0 grant
//   st_vld_xx/st_be_xx/st_data_xx/st_addr_xx : store drain; st_ack_xx ack
//   fill_req_xx/fill_addr_xx/fill_data_xx    : fill beat; fill_gnt_xx grant
//   dc_en_xx/dc_we_xx/dc_be_xx/dc_addr_xx/dc_wdata_xx/dc_src_xx :
//                               registered D$ command (src 0=ld 1=st 2=fill)
// -----------------------------------------------------------------------------
module dcache_port_arb #(
    parameter int unsigned VA_BITS    = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned FILL_BEATS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ld_req_e0,
    input  logic [VA_BITS-1:0] ld_va_e0,
    output logic               ld_gnt_e0,
    input  logic               st_vld_xx,
    input  logic [7:0]         st_be_xx,
    input  logic [63:0]        st_data_xx,
    input  logic [VA_BITS-1:0] st_addr_xx,
    output logic               st_ack_xx,
    input  logic               fill_req_xx,
    input  logic [VA_BITS-1:0] fill_addr_xx,
    input  logic [63:0]        fill_data_xx,
    output logic               fill_gnt_xx,
    output logic               dc_en_xx,
    output logic               dc_we_xx,
    output logic [7:0]         dc_be_xx,
    output logic [VA_BITS-1:0] dc_addr_xx,
    output logic [63:0]        dc_wdata_xx,
    output logic [1:0]         dc_src_xx
);

    localparam int unsigned CNT_W = $clog2(FILL_BEATS);

    if (FILL_BEATS < 2 || FILL_BEATS > 8 || (FILL_BEATS & (FILL_BEATS - 1)) != 0) begin : g_bad_beats
        $error("dcache_port_arb: FILL_BEATS must be a power of 2 in 2..8");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
        $error("dcache_port_arb: STARVE_MAX must be in 1..15");
    end

    typedef enum logic {
        S_ARB  = 1'b0,
        S_FILL = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] beat_q,  beat_d;

    logic             ld_gnt, st_gnt, fill_gnt;
    logic             st_starved;

    logic             dc_en_q;
    logic             dc_we_q;
    logic [7:0]       dc_be_q;
    logic [VA_BITS-1:0] dc_addr_q;
    logic [63:0]      dc_wdata_q;
    logic [1:0]       dc_src_q;

`ifdef DCARB_STARVE_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] st_wait_q, st_wait_d;

    assign st_starved = (st_wait_q == STARVE_LIM);

    // Counts arbitration cycles in which a valid store lost. Frozen during a
    // fill burst so a burst neither promotes nor demotes the store.
    always_comb begin
        st_wait_d = st_wait_q;
        if (st_gnt) begin
            st_wait_d = 4'd0;
        end else if (state_q == S_ARB && st_vld_xx && !st_starved) begin
            st_wait_d = st_wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_wait_q <= 4'd0;
        end else begin
            st_wait_q <= st_wait_d;
        end
    end
`else
    assign st_starved = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_ARB;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Next state. beat_q holds the beats still owed after the one that opened
    // the burst; the beat that drains it to zero releases the port on the
    // same edge, so a burst is exactly FILL_BEATS grants.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        unique case (state_q)
            S_ARB: begin
                if (fill_gnt) begin
                    state_d = S_FILL;
                    beat_d  = CNT_W'(FILL_BEATS - 1);
                end
            end
            S_FILL: begin
                if (fill_gnt) begin
                    beat_d = beat_q - CNT_W'(1);
                    if (beat_q == CNT_W'(1)) begin
                        state_d = S_ARB;
                    end
                end
            end
            default: begin
                state_d = S_ARB;
                beat_d  = '0;
            end
        endcase
    end

    // Grants. Forced low while reset is held; inside a burst only the fill
    // engine may use the port, even if it pauses.
    always_comb begin
        ld_gnt   = 1'b0;
        st_gnt   = 1'b0;
        fill_gnt = 1'b0;
        if (reset) begin
            unique case (state_q)
                S_ARB: begin
                    if (fill_req_xx) begin
                        fill_gnt = 1'b1;
                    end else if (st_vld_xx && st_starved) begin
                        st_gnt = 1'b1;
                    end else if (ld_req_e0) begin
                        ld_gnt = 1'b1;
                    end else if (st_vld_xx) begin
                        st_gnt = 1'b1;
                    end
                end
                S_FILL: begin
                    fill_gnt = fill_req_xx;
                end
                default: begin
                    fill_gnt = 1'b0;
                end
            endcase
        end
    end

    assign ld_gnt_e0   = ld_gnt;
    assign st_ack_xx   = st_gnt;
    assign fill_gnt_xx = fill_gnt;

    // D$ command register: dc_en pulses for one cycle per grant; the payload
    // fields keep the last winner's values when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dc_en_q    <= 1'b0;
            dc_we_q    <= 1'b0;
            dc_be_q    <= 8'h00;
            dc_addr_q  <= '0;
            dc_wdata_q <= 64'h0;
            dc_src_q   <= 2'd0;
        end else begin
            dc_en_q <= ld_gnt | st_gnt | fill_gnt;
            if (fill_gnt) begin
                dc_we_q    <= 1'b1;
                dc_be_q    <= 8'hff;
                dc_addr_q  <= fill_addr_xx;
                dc_wdata_q <= fill_data_xx;
                dc_src_q   <= 2'd2;
            end else if (st_gnt) begin
                dc_we_q    <= 1'b1;
                dc_be_q    <= st_be_xx;
                dc_addr_q  <= st_addr_xx;
                dc_wdata_q <= st_data_xx;
                dc_src_q   <= 2'd1;
            end else if (ld_gnt) begin
                dc_we_q    <= 1'b0;
                dc_be_q    <= 8'h00;
                dc_addr_q  <= ld_va_e0;
                dc_wdata_q <= 64'h0;
                dc_src_q   <= 2'd0;
            end
        end
    end

    assign dc_en_xx    = dc_en_q;
    assign dc_we_xx    = dc_we_q;
    assign dc_be_xx    = dc_be_q;
    assign dc_addr_xx  = dc_addr_q;
    assign dc_wdata_xx = dc_wdata_q;
    assign dc_src_xx   = dc_src_q;

endmodule

// File: tb/tb_dcache_port_arb.sv
`timescale 1ns/1ps
module tb_dcache_port_arb;

    localparam int VA = 32;

    localparam logic [2:0] G_NO = 3'b000;
    localparam logic [2:0] G_FL = 3'b001;
    localparam logic [2:0] G_ST = 3'b010;
    localparam logic [2:0] G_LD = 3'b100;

    logic          clk = 1'b0;
    logic          reset;
    logic          ld_req_e0;
    logic [VA-1:0] ld_va_e0;
    logic          ld_gnt_e0;
    logic          st_vld_xx;
    logic [7:0]    st_be_xx;
    logic [63:0]   st_data_xx;
    logic [VA-1:0] st_addr_xx;
    logic          st_ack_xx;
    logic          fill_req_xx;
    logic [VA-1:0] fill_addr_xx;
    logic [63:0]   fill_data_xx;
    logic          fill_gnt_xx;
    logic          dc_en_xx;
    logic          dc_we_xx;
    logic [7:0]    dc_be_xx;
    logic [VA-1:0] dc_addr_xx;
    logic [63:0]   dc_wdata_xx;
    logic [1:0]    dc_src_xx;

    always #5 clk = ~clk;

    dcache_port_arb #(
        .VA_BITS   (VA),
        .STARVE_MAX(4),
        .FILL_BEATS(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ld_req_e0   (ld_req_e0),
        .ld_va_e0    (ld_va_e0),
        .ld_gnt_e0   (ld_gnt_e0),
        .st_vld_xx   (st_vld_xx),
        .st_be_xx    (st_be_xx),
        .st_data_xx  (st_data_xx),
        .st_addr_xx  (st_addr_xx),
        .st_ack_xx   (st_ack_xx),
        .fill_req_xx (fill_req_xx),
        .fill_addr_xx(fill_addr_xx),
        .fill_data_xx(fill_data_xx),
        .fill_gnt_xx (fill_gnt_xx),
        .dc_en_xx    (dc_en_xx),
        .dc_we_xx    (dc_we_xx),
        .dc_be_xx    (dc_be_xx),
        .dc_addr_xx  (dc_addr_xx),
        .dc_wdata_xx (dc_wdata_xx),
        .dc_src_xx   (dc_src_xx)
    );

    typedef struct packed {
        logic          en;
        logic          we;
        logic [7:0]    be;
        logic [VA-1:0] addr;
        logic [63:0]   wdata;
        logic [1:0]    src;
    } cmd_t;

    cmd_t exp_q[$];
    cmd_t last_cmd;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t dut_cmd();
        cmd_t c;
        c.en    = dc_en_xx;
        c.we    = dc_we_xx;
        c.be    = dc_be_xx;
        c.addr  = dc_addr_xx;
        c.wdata = dc_wdata_xx;
        c.src   = dc_src_xx;
        return c;
    endfunction

    // Expected command one cycle after a grant of kind g, from current inputs.
    task automatic push_exp(input logic [2:0] g);
        cmd_t c;
        c    = last_cmd;
        c.en = 1'b0;
        case (g)
            G_LD: begin
                c.en = 1'b1; c.we = 1'b0; c.be = 8'h00;
                c.addr = ld_va_e0; c.wdata = 64'h0; c.src = 2'd0;
            end
            G_ST: begin
                c.en = 1'b1; c.we = 1'b1; c.be = st_be_xx;
                c.addr = st_addr_xx; c.wdata = st_data_xx; c.src = 2'd1;
            end
            G_FL: begin
                c.en = 1'b1; c.we = 1'b1; c.be = 8'hff;
                c.addr = fill_addr_xx; c.wdata = fill_data_xx; c.src = 2'd2;
            end
            default: ;
        endcase
        if (g != G_NO) last_cmd = c;
        exp_q.push_back(c);
    endtask

    // Inputs are set by the caller just after a rising edge; checks happen on
    // the falling edge, then the bench advances to just after the next rise.
    task automatic step(input logic [2:0] g, input string tag);
        cmd_t e;
        @(negedge clk);
        e = exp_q.pop_front();
        chk({tag, "_cmd"}, 128'(dut_cmd()), 128'(e));
        chk({tag, "_gnt"}, 128'({ld_gnt_e0, st_ack_xx, fill_gnt_xx}), 128'(g));
        push_exp(g);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        last_cmd     = '0;
        reset        = 1'b0;
        ld_req_e0    = 1'b1;
        ld_va_e0     = 32'h0000_3000;
        st_vld_xx    = 1'b1;
        st_be_xx     = 8'h0f;
        st_data_xx   = 64'h1111_2222_3333_4444;
        st_addr_xx   = 32'h0000_4000;
        fill_req_xx  = 1'b1;
        fill_addr_xx = 32'h0000_2000;
        fill_data_xx = 64'hf111_0000_0000_0000;

        // Reset held with every requester active.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_gnt", 128'({ld_gnt_e0, st_ack_xx, fill_gnt_xx}), 128'(G_NO));
            chk("rst_cmd", 128'(dut_cmd()), 128'(0));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.push_back('0);

        // Fill wins first after release and holds the port for 4 beats.
        for (int i = 0; i < 4; i++) begin
            fill_addr_xx = 32'h0000_2000 + 32'(i * 8);
            fill_data_xx = 64'hf111_0000_0000_0000 | 64'(i);
            step(G_FL, "rel_fill");
        end

        // Lone store: clears any accumulated wait.
        fill_req_xx = 1'b0;
        ld_req_e0   = 1'b0;
        step(G_ST, "st_alone");

        // Load/store conflict every cycle.
        ld_req_e0  = 1'b1;
        st_be_xx   = 8'hf0;
        st_data_xx = 64'hdead_beef_0000_0001;
        st_addr_xx = 32'h0000_4010;
        for (int i = 0; i < 6; i++) begin
            ld_va_e0 = 32'h0000_3100 + 32'(i * 8);
`ifdef DCARB_STARVE_EN
            step((i == 4) ? G_ST : G_LD, "conflict");
`else
            step(G_LD, "conflict");
`endif
        end
        ld_req_e0 = 1'b0;
        step(G_ST, "st_noload");
        st_vld_xx = 1'b0;

        // Fill burst with a 2-cycle pause after beat 1, load requested throughout.
        ld_req_e0    = 1'b1;
        ld_va_e0     = 32'h0000_3200;
        fill_req_xx  = 1'b1;
        fill_addr_xx = 32'h0000_5000;
        fill_data_xx = 64'ha5a5_0000_0000_0000;
        step(G_FL, "gap_b1");
        fill_req_xx = 1'b0;
        step(G_NO, "gap_idle");
        step(G_NO, "gap_idle");
        fill_req_xx = 1'b1;
        for (int i = 1; i < 4; i++) begin
            fill_addr_xx = 32'h0000_5000 + 32'(i * 8);
            fill_data_xx = 64'ha5a5_0000_0000_0000 | 64'(i);
            step(G_FL, "gap_beat");
        end
        fill_req_xx = 1'b0;
        step(G_LD, "gap_after");

        // Store starves behind loads, then a fill arrives alongside load and store.
        st_vld_xx  = 1'b1;
        st_be_xx   = 8'h3c;
        st_data_xx = 64'h0123_4567_89ab_cdef;
        st_addr_xx = 32'h0000_4020;
        for (int i = 0; i < 4; i++) begin
            ld_va_e0 = 32'h0000_3300 + 32'(i * 8);
            step(G_LD, "pre_starve");
        end
        fill_req_xx = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fill_addr_xx = 32'h0000_6000 + 32'(i * 8);
            fill_data_xx = 64'hc3c3_0000_0000_0000 | 64'(i);
            step(G_FL, "starve_fill");
        end
        fill_req_xx = 1'b0;
`ifdef DCARB_STARVE_EN
        step(G_ST, "post_burst");
        st_vld_xx = 1'b0;
        step(G_LD, "post_burst");
`else
        step(G_LD, "post_burst");
        ld_req_e0 = 1'b0;
        step(G_ST, "post_burst");
        st_vld_xx = 1'b0;
`endif
        ld_req_e0 = 1'b0;
        step(G_NO, "idle");

        // Reset mid-burst after beat 2.
        ld_req_e0    = 1'b1;
        ld_va_e0     = 32'h0000_3400;
        fill_req_xx  = 1'b1;
        fill_addr_xx = 32'h0000_7000;
        fill_data_xx = 64'h7777_0000_0000_0000;
        step(G_FL, "mid_b1");
        fill_addr_xx = 32'h0000_7008;
        fill_data_xx = 64'h7777_0000_0000_0001;
        step(G_FL, "mid_b2");
        reset = 1'b0;
        #1;
        chk("mid_rst_gnt", 128'({ld_gnt_e0, st_ack_xx, fill_gnt_xx}), 128'(G_NO));
        chk("mid_rst_en", 128'(dc_en_xx), 128'(0));
        exp_q.delete();
        last_cmd = '0;
        @(posedge clk);
        #1;
        reset       = 1'b1;
        fill_req_xx = 1'b0;
        exp_q.push_back('0);
        step(G_LD, "mid_rel_ld");
        ld_req_e0 = 1'b0;
        step(G_NO, "mid_idle");

        // Single store handshake.
        st_vld_xx  = 1'b1;
        st_be_xx   = 8'h0c;
        st_addr_xx = 32'h0000_1008;
        st_data_xx = 64'h0000_abcd_0000_0000;
        step(G_ST, "st_hs");
        st_vld_xx = 1'b0;
        step(G_NO, "st_hs_cmd");
        step(G_NO, "st_hs_hold");

        @(negedge clk);
        chk("final_cmd", 128'(dut_cmd()), 128'(exp_q.pop_front()));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
